z80_bus_responder: RTL and testbench

Z80-bus I/O peripheral that answers the bus cycles issued by the on-chip `z80` core: a decoded 4-register I/O window with programmable wait states, an 8-bit GPIO, and a reload timer that raises `/INT`. During interrupt acknowledge it returns an IM2 vector. It sits beside the CPU on the same clock, connected to its `A`, `dout`, `di` and control strobes.

---
 rtl/z80_resp_pkg.sv | 22 ++
 rtl/z80_resp_timer.sv | 38 +++
 rtl/z80_bus_responder.sv | 155 +++++++++++++++
 tb/tb_z80_bus_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/z80_resp_pkg.sv
// Shared definitions for the Z80 bus responder: register offsets,
// CTRL bit positions and the bus-cycle FSM state encoding.
package z80_resp_pkg;

  localparam logic [1:0] REG_GPO    = 2'd0;
  localparam logic [1:0] REG_GPI    = 2'd1;
  localparam logic [1:0] REG_RELOAD = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int TEN  = 0;
  localparam int IEN  = 1;
  localparam int PEND = 7;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    XFER,
    HOLD,
    ACK
  } state_t;

endpackage

// File: rtl/z80_resp_timer.sv
// Reload down-counter that raises a sticky pending flag on expiry.
// A simultaneous expiry and clear leaves the flag set.
module z80_resp_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ten,
  input  logic [7:0] reload,
  input  logic       load,
  input  logic       clr,
  output logic       pend
);

  logic [7:0] count;
  logic       expire;

  assign expire = ten && (count == 8'd0);

  // reload carries the freshly written value when load is high, so a write
  // landing on an expiry cycle still wins the counter value
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= 8'd0;
      pend  <= 1'b0;
    end else begin
      if (load || expire) begin
        count <= reload;
      end else if (ten) begin
        count <= count - 8'd1;
      end
      if (expire) begin
        pend <= 1'b1;
      end else if (clr) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 I/O peripheral: decoded 4-register window with wait states, GPIO,
// reload timer driving /INT, and an IM2 vector on interrupt acknowledge.
module z80_bus_responder
  import z80_resp_pkg::*;
#(
  parameter logic [7:0] IO_BASE     = 8'h10,
  parameter int         WAIT_STATES = 2,
  parameter logic [7:0] IM2_VECTOR  = 8'hE0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] A,
  input  logic [7:0] di,
  input  logic       m1_n,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  output logic [7:0] dout,
  output logic       doe,
  output logic       wait_n,
  output logic       int_n,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out
);

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  state_t     state, state_next;
  logic [3:0] wait_cnt, wait_cnt_next;
  logic       ack_hold, ack_hold_next;
  logic       hit, inta, commit, wait_low, load, clr, in_ack;
  logic [7:0] gpo, reload_q, rd_data, reload_val;
  logic       ten, ien, pend;

  assign hit    = !iorq_n && m1_n && (A[7:2] == IO_BASE[7:2]);
  assign inta   = !iorq_n && !m1_n;
  assign in_ack = (state == ACK) || ((state == HOLD) && ack_hold);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      ack_hold <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      ack_hold <= ack_hold_next;
    end
  end

  // The IDLE hit cycle is the first wait cycle, so WAIT counts the rest and
  // spends one final cycle with wait_n released before moving to XFER.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    ack_hold_next = ack_hold;
    commit        = 1'b0;
    wait_low      = 1'b0;
    case (state)
      IDLE: begin
        ack_hold_next = 1'b0;
        if (hit) begin
          if (WAIT_STATES > 0) begin
            state_next    = WAIT;
            wait_cnt_next = WAIT_LOAD;
            wait_low      = 1'b1;
          end else begin
            state_next = XFER;
          end
        end else if (inta) begin
          state_next    = ACK;
          ack_hold_next = 1'b1;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = XFER;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
          wait_low      = 1'b1;
        end
      end
      XFER: begin
        commit     = !wr_n;
        state_next = HOLD;
      end
      HOLD: begin
        if (iorq_n) state_next = IDLE;
      end
      ACK: begin
        state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wait_n = !(reset_n && wait_low);
  assign doe    = reset_n && ((hit && !rd_n && (state != ACK)) || (!iorq_n && in_ack));

  assign load       = commit && (A[1:0] == REG_RELOAD);
  assign reload_val = load ? di : reload_q;
  assign clr        = ((state == IDLE) && inta) || (commit && (A[1:0] == REG_CTRL) && di[PEND]);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gpo      <= 8'd0;
      reload_q <= 8'd0;
      ten      <= 1'b0;
      ien      <= 1'b0;
      int_n    <= 1'b1;
    end else begin
      int_n <= !(pend && ien);
      if (commit) begin
        case (A[1:0])
          REG_GPO:    gpo      <= di;
          REG_RELOAD: reload_q <= di;
          REG_CTRL: begin
            ten <= di[TEN];
            ien <= di[IEN];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = 8'd0;
    if (in_ack) begin
      rd_data = IM2_VECTOR;
    end else begin
      case (A[1:0])
        REG_GPO:    rd_data = gpo;
        REG_GPI:    rd_data = gpio_in;
        REG_RELOAD: rd_data = reload_q;
        REG_CTRL:   rd_data = {pend, 5'd0, ien, ten};
        default:    rd_data = 8'd0;
      endcase
    end
  end

  assign dout     = doe ? rd_data : 8'd0;
  assign gpio_out = gpo;

  z80_resp_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .ten     (ten),
    .reload  (reload_val),
    .load    (load),
    .clr     (clr),
    .pend    (pend)
  );

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: read data flows through a scoreboard
// queue checked by an independent monitor; timing and side effects checked inline.
module tb_z80_bus_responder;

  typedef struct {
    string      name;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] a_bus = 8'h00, di_bus = 8'h00, gpio_in = 8'h00;
  logic       m1_bus = 1'b1, iorq_bus = 1'b1, rd_bus = 1'b1, wr_bus = 1'b1;
  logic       sel = 1'b0;
  logic       doe_prev = 1'b0, doe_any = 1'b0;

  logic [7:0] dout2, gpo2, dout0, gpo0;
  logic       doe2, wait2, int2, doe0, wait0, int0;
  logic [7:0] dout_s;
  logic       doe_s, wait_s, int_s;

  always #5 clk = ~clk;

  // sel routes the shared bus either to the default instance (0) or to the zero-wait one (1)
  z80_bus_responder dut (
    .clk(clk), .reset_n(reset_n), .A(a_bus), .di(di_bus),
    .m1_n(sel ? 1'b1 : m1_bus), .iorq_n(sel ? 1'b1 : iorq_bus),
    .rd_n(sel ? 1'b1 : rd_bus), .wr_n(sel ? 1'b1 : wr_bus),
    .dout(dout2), .doe(doe2), .wait_n(wait2), .int_n(int2),
    .gpio_in(gpio_in), .gpio_out(gpo2)
  );

  z80_bus_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .A(a_bus), .di(di_bus),
    .m1_n(sel ? m1_bus : 1'b1), .iorq_n(sel ? iorq_bus : 1'b1),
    .rd_n(sel ? rd_bus : 1'b1), .wr_n(sel ? wr_bus : 1'b1),
    .dout(dout0), .doe(doe0), .wait_n(wait0), .int_n(int0),
    .gpio_in(gpio_in), .gpio_out(gpo0)
  );

  assign dout_s = sel ? dout0 : dout2;
  assign doe_s  = sel ? doe0  : doe2;
  assign wait_s = sel ? wait0 : wait2;
  assign int_s  = sel ? int0  : int2;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic expect_read(input string name, input logic [7:0] data);
    exp_t e;
    e.name = name;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // kind: 0 read, 1 write, 2 interrupt acknowledge
  task automatic bus(input bit s, input int kind, input logic [7:0] addr,
                     input logic [7:0] data, output int waits);
    bit done = 1'b0;
    @(posedge clk); #1;
    sel = s; a_bus = addr; di_bus = data; doe_any = 1'b0;
    iorq_bus = 1'b0;
    if (kind == 0) rd_bus = 1'b0;
    if (kind == 1) wr_bus = 1'b0;
    if (kind == 2) m1_bus = 1'b0;
    waits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!wait_s) waits++;
      else begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("wait_timeout", 8'd1, 8'd0);
    @(posedge clk);
    @(posedge clk); #1;
    iorq_bus = 1'b1; rd_bus = 1'b1; wr_bus = 1'b1; m1_bus = 1'b1;
  endtask

  always @(negedge clk) begin
    if (doe_s) doe_any = 1'b1;
    if (doe_s && !doe_prev) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_doe: got dout %h, expected no read", dout_s);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (dout_s === e.data) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", e.name, dout_s, e.data);
      end
    end
    doe_prev = doe_s;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int   w, cnt;
    bit   found;
    logic exp_int[4];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_doe", {7'd0, doe_s}, 8'd0);
    check("rst_wait_n", {7'd0, wait_s}, 8'd1);
    check("rst_int_n", {7'd0, int_s}, 8'd1);
    check("rst_gpio_out", gpo2, 8'h00);
    check("rst_dout", dout_s, 8'h00);
    @(posedge clk); #1 reset_n = 1'b1;

    // reset asserted while the write of A5 sits in WAIT
    @(posedge clk); #1;
    a_bus = 8'h10; di_bus = 8'hA5; iorq_bus = 1'b0; wr_bus = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_doe", {7'd0, doe_s}, 8'd0);
    check("midrst_wait_n", {7'd0, wait_s}, 8'd1);
    check("midrst_int_n", {7'd0, int_s}, 8'd1);
    check("midrst_dout", dout_s, 8'h00);
    iorq_bus = 1'b1; wr_bus = 1'b1;
    repeat (2) @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_gpio_out", gpo2, 8'h00);

    bus(0, 1, 8'h10, 8'h3C, w);
    check("wr_gpo_waits", 8'(w), 8'd2);
    @(negedge clk);
    check("wr_gpo_value", gpo2, 8'h3C);

    gpio_in = 8'h5A;
    expect_read("rd_gpi", 8'h5A);
    bus(0, 0, 8'h11, 8'h00, w);
    check("rd_gpi_waits", 8'(w), 8'd2);
    @(negedge clk);
    check("rd_gpi_doe_after", {7'd0, doe_s}, 8'd0);

    bus(0, 0, 8'h14, 8'h00, w);
    check("miss_waits", 8'(w), 8'd0);
    check("miss_doe", {7'd0, doe_any}, 8'd0);

    expect_read("rd_gpo", 8'h3C);
    bus(0, 0, 8'h10, 8'h00, w);

    // reload 3 with TEN|IEN: expiry every 4 edges, the first 4 edges after the CTRL commit
    bus(0, 1, 8'h12, 8'h03, w);
    bus(0, 1, 8'h13, 8'h03, w);
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!int_s) begin
        found = 1'b1;
        break;
      end
      cnt++;
    end
    check("int_latency", 8'(cnt), 8'd5);

    // clear two edges before the next expiry: int_n rises, then falls again
    bus(0, 1, 8'h13, 8'h83, w);
    exp_int[0] = 1'b0; exp_int[1] = 1'b1; exp_int[2] = 1'b1; exp_int[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("clr_int_n_%0d", i), {7'd0, int_s}, {7'd0, exp_int[i]});
    end

    // clear committed on the very edge of an expiry: the set wins
    repeat (2) @(posedge clk);
    bus(0, 1, 8'h13, 8'h83, w);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("coll_int_n_%0d", i), {7'd0, int_s}, 8'd0);
    end
    expect_read("coll_ctrl", 8'h83);
    bus(0, 0, 8'h13, 8'h00, w);

    bus(0, 1, 8'h13, 8'h02, w);
    @(negedge clk);
    check("pre_inta_int_n", {7'd0, int_s}, 8'd0);
    expect_read("inta_vector", 8'hE0);
    bus(0, 2, 8'h00, 8'h00, w);
    check("inta_waits", 8'(w), 8'd0);
    @(negedge clk);
    check("post_inta_int_n", {7'd0, int_s}, 8'd1);

    expect_read("rd_reload", 8'h03);
    bus(0, 0, 8'h12, 8'h00, w);

    bus(1, 1, 8'h12, 8'h40, w);
    check("ws0_reload_waits", 8'(w), 8'd0);
    bus(1, 1, 8'h13, 8'h03, w);
    check("ws0_ctrl_waits", 8'(w), 8'd0);
    expect_read("ws0_ctrl", 8'h03);
    bus(1, 0, 8'h13, 8'h00, w);
    check("ws0_rd_waits", 8'(w), 8'd0);

    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("[TB] FAIL scoreboard_drain: got %0d pending reads, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
